// File: rtl/word_matcher_pkg.sv
// Shared types, sizes and helpers for the word matcher slice.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package word_match_pkg;

  localparam int CHAR_W   = 8;
  localparam int MAX_WORD = 8;
  localparam int POS_W    = 8;
  localparam int FILL_W   = 4;   // holds 0..MAX_WORD

  // End-of-stream command byte, shared with the upstream SPI controller.
  localparam logic [CHAR_W-1:0] CMD_END = 8'h01;

  typedef logic [CHAR_W-1:0]                char_t;
  typedef logic [MAX_WORD-1:0][CHAR_W-1:0]  window_t;

  // Byte idx of a MAX_WORD-character bus; byte 0 sits in the low bits.
  function automatic char_t get_byte(input logic [MAX_WORD*CHAR_W-1:0] bus,
                                     input logic [2:0]                 idx);
    return bus[{idx, 3'b000} +: CHAR_W];
  endfunction

endpackage

// File: rtl/word_matcher_if.sv
// Character/result stream bundle (valid, data, end-of-stream user bit).
// Latency: n/a (wires only).
// Backpressure: none; there is no ready, every valid beat is consumed.
// Ports: tvalid - beat valid, tdata - character or result id, tuser - end marker.
interface word_matcher_if;
  import word_match_pkg::*;

  logic  tvalid;
  char_t tdata;
  logic  tuser;

  modport master (output tvalid, tdata, tuser);
  modport slave  (input  tvalid, tdata, tuser);

endinterface

// File: rtl/word_matcher_char_window.sv
// Sliding window of the last MAX_WORD characters plus fill and position counters.
// Latency: window/fill/pos_q/chr_q update on the edge that samples the beat.
// Backpressure: none; every valid beat is taken.
// Ports: in_vld/in_dat/in_end - incoming beat; win - w[0] newest .. w[7] oldest;
//        fill - characters held (saturates); pos_q - position of last character;
//        chr_q - last edge sampled a character beat (not an end beat).
module char_window
  import word_match_pkg::*;
(
  input  logic              aclk,
  input  logic              areset,
  input  logic              in_vld,
  input  char_t             in_dat,
  input  logic              in_end,
  output window_t           win,
  output logic [FILL_W-1:0] fill,
  output logic [POS_W-1:0]  pos_q,
  output logic              chr_q
);

  logic [POS_W-1:0] position;

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      win      <= '0;
      fill     <= '0;
      position <= '0;
      pos_q    <= '0;
      chr_q    <= 1'b0;
    end else begin
      chr_q <= in_vld & ~in_end;
      if (in_vld) begin
        if (in_end) begin
          // End beat restarts the word; window contents are left alone
          // because fill=0 blocks any compare against stale characters.
          fill     <= '0;
          position <= '0;
        end else begin
          win      <= {win[MAX_WORD-2:0], in_dat};
          pos_q    <= position;
          position <= position + POS_W'(1);
          if (fill != FILL_W'(MAX_WORD)) begin
            fill <= fill + FILL_W'(1);
          end
        end
      end
    end
  end

endmodule

// File: rtl/word_matcher.sv
// Streaming matcher: compares the last word_size characters to a masked pattern.
// Latency: result pulse 2 edges after the edge that samples the final character.
// Backpressure: none on either side; one result per cycle, overlapping hits back-to-back.
// Ports: aclk/areset - clock, async active-high reset; word_size, result_mask,
//        characters, masks - config; s_axis - character stream in (tuser = end);
//        m_axis - result ids out (tuser tied low).
module word_matcher
  import word_match_pkg::*;
(
  input  logic                       aclk,
  input  logic                       areset,
  input  logic [7:0]                 word_size,
  input  logic [POS_W-1:0]           result_mask,
  input  logic [MAX_WORD*CHAR_W-1:0] characters,
  input  logic [MAX_WORD*CHAR_W-1:0] masks,
  word_matcher_if.slave              s_axis,
  word_matcher_if.master             m_axis
);

  window_t           win;
  logic [FILL_W-1:0] fill;
  logic [POS_W-1:0]  pos_q;
  logic              chr_q;

  char_window u_char_window (
    .aclk   (aclk),
    .areset (areset),
    .in_vld (s_axis.tvalid),
    .in_dat (s_axis.tdata),
    .in_end (s_axis.tuser),
    .win    (win),
    .fill   (fill),
    .pos_q  (pos_q),
    .chr_q  (chr_q)
  );

  // Compare stage. Pattern character 0 is the oldest of the last word_size
  // characters, i.e. w[word_size-1]; the newest character lines up with
  // pattern character word_size-1.
  logic              ws_ok;
  logic [FILL_W-1:0] ws4;
  logic [2:0]        idx;
  char_t             diff;
  logic              all_hit;
  logic              match_c;

  assign ws_ok = (word_size != 8'd0) && (word_size <= 8'(MAX_WORD));
  assign ws4   = word_size[FILL_W-1:0];

  always_comb begin
    idx     = '0;
    diff    = '0;
    all_hit = 1'b1;
    for (int i = 0; i < MAX_WORD; i++) begin
      if (FILL_W'(i) < ws4) begin
        idx  = 3'(ws4 - FILL_W'(1) - FILL_W'(i));
        diff = (win[idx] ^ get_byte(characters, 3'(i))) & ~get_byte(masks, 3'(i));
        if (diff != '0) begin
          all_hit = 1'b0;
        end
      end
    end
    match_c = chr_q && ws_ok && (fill >= ws4) && all_hit;
  end

  logic             match_q;
  logic [POS_W-1:0] pos_s1;
  logic             out_vld;
  logic [POS_W-1:0] out_dat;

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      match_q <= 1'b0;
      pos_s1  <= '0;
      out_vld <= 1'b0;
      out_dat <= '0;
    end else begin
      match_q <= match_c;
      pos_s1  <= pos_q;
      out_vld <= match_q;
      if (match_q) begin
        out_dat <= pos_s1 & result_mask;
      end
    end
  end

  assign m_axis.tvalid = out_vld;
  assign m_axis.tdata  = out_dat;
  assign m_axis.tuser  = 1'b0;

endmodule

// File: tb/tb_word_matcher.sv
// Directed bench for word_matcher: hand-computed result ids and pulse timing.
module tb_word_matcher;
  import word_match_pkg::*;

  logic        aclk = 1'b0;
  logic        areset;
  logic [7:0]  word_size;
  logic [7:0]  result_mask;
  logic [63:0] characters;
  logic [63:0] masks;

  always #5 aclk = ~aclk;

  word_matcher_if s_axis ();
  word_matcher_if m_axis ();

  word_matcher dut (
    .aclk        (aclk),
    .areset      (areset),
    .word_size   (word_size),
    .result_mask (result_mask),
    .characters  (characters),
    .masks       (masks),
    .s_axis      (s_axis),
    .m_axis      (m_axis)
  );

  int         checks   = 0;
  int         failures = 0;
  logic       ov [64];
  logic [7:0] od [64];
  int         nsamp;

  // Sample outputs at the falling edge, then drive the next input beat.
  // A beat driven in slot n produces its result in sample slot n+3.
  task automatic step(input logic v, input logic [7:0] d, input logic u);
    @(negedge aclk);
    if (nsamp < 64) begin
      ov[nsamp] = m_axis.tvalid;
      od[nsamp] = m_axis.tdata;
    end
    nsamp++;
    s_axis.tvalid = v;
    s_axis.tdata  = d;
    s_axis.tuser  = u;
  endtask

  // '|' is an end beat, '.' an idle cycle, anything else a character.
  task automatic run(input string s);
    nsamp = 0;
    for (int i = 0; i < s.len(); i++) begin
      byte c;
      c = s[i];
      if (c == "|")      step(1'b1, CMD_END, 1'b1);
      else if (c == ".") step(1'b0, 8'h00, 1'b0);
      else               step(1'b1, c, 1'b0);
    end
    for (int i = 0; i < 5; i++) step(1'b0, 8'h00, 1'b0);
  endtask

  function automatic int count_pulses();
    int n = 0;
    for (int i = 0; i < nsamp && i < 64; i++) if (ov[i] === 1'b1) n++;
    return n;
  endfunction

  task automatic do_reset();
    areset        = 1'b1;
    s_axis.tvalid = 1'b0;
    s_axis.tdata  = 8'h00;
    s_axis.tuser  = 1'b0;
    repeat (2) @(negedge aclk);
    areset = 1'b0;
  endtask

  task automatic cfg(input logic [7:0] ws, input logic [63:0] ch,
                     input logic [63:0] mk, input logic [7:0] rm);
    word_size   = ws;
    characters  = ch;
    masks       = mk;
    result_mask = rm;
  endtask

  task automatic test_reset();
    areset        = 1'b1;
    s_axis.tvalid = 1'b1;
    s_axis.tdata  = "a";
    s_axis.tuser  = 1'b0;
    cfg(8'd1, 64'h61, 64'h0, 8'hFF);
    repeat (3) begin
      @(negedge aclk);
      checks++;
      if (m_axis.tvalid !== 1'b0 || m_axis.tdata !== 8'h00) begin
        failures++;
        $display("FAIL reset_outputs got vld=%b id=%h exp vld=0 id=00", m_axis.tvalid, m_axis.tdata);
      end
    end
    s_axis.tvalid = 1'b0;
    areset = 1'b0;
  endtask

  task automatic test_basic();
    int n;
    do_reset();
    cfg(8'd3, 64'h636261, 64'h0, 8'hFF);
    run("xabcabc");
    n = count_pulses();
    checks++;
    if (n !== 2) begin failures++; $display("FAIL basic_count got=%0d exp=2", n); end
    checks++;
    if (ov[6] !== 1'b1 || od[6] !== 8'h03) begin
      failures++; $display("FAIL basic_first got vld=%b id=%h exp vld=1 id=03", ov[6], od[6]);
    end
    checks++;
    if (ov[9] !== 1'b1 || od[9] !== 8'h06) begin
      failures++; $display("FAIL basic_second got vld=%b id=%h exp vld=1 id=06", ov[9], od[9]);
    end

    do_reset();
    cfg(8'd3, 64'h636261, 64'h0, 8'h03);
    run("xabcabc");
    n = count_pulses();
    checks++;
    if (n !== 2) begin failures++; $display("FAIL rmask_count got=%0d exp=2", n); end
    checks++;
    if (ov[6] !== 1'b1 || od[6] !== 8'h03) begin
      failures++; $display("FAIL rmask_first got vld=%b id=%h exp vld=1 id=03", ov[6], od[6]);
    end
    checks++;
    if (ov[9] !== 1'b1 || od[9] !== 8'h02) begin
      failures++; $display("FAIL rmask_second got vld=%b id=%h exp vld=1 id=02", ov[9], od[9]);
    end
  endtask

  task automatic test_mask();
    int n;
    do_reset();
    cfg(8'd3, 64'h636261, 64'h2000, 8'hFF);
    run("aBc");
    n = count_pulses();
    checks++;
    if (n !== 1) begin failures++; $display("FAIL mask_hit_count got=%0d exp=1", n); end
    checks++;
    if (ov[5] !== 1'b1 || od[5] !== 8'h02) begin
      failures++; $display("FAIL mask_hit got vld=%b id=%h exp vld=1 id=02", ov[5], od[5]);
    end
    do_reset();
    run("aXc");
    n = count_pulses();
    checks++;
    if (n !== 0) begin failures++; $display("FAIL mask_miss got=%0d pulses exp=0", n); end
  endtask

  task automatic test_back_to_back();
    int n;
    do_reset();
    cfg(8'd2, 64'h6161, 64'h0, 8'hFF);
    run("aaaa");
    n = count_pulses();
    checks++;
    if (n !== 3) begin failures++; $display("FAIL b2b_count got=%0d exp=3", n); end
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (ov[4+k] !== 1'b1 || od[4+k] !== 8'(k + 1)) begin
        failures++;
        $display("FAIL b2b_pulse%0d got vld=%b id=%h exp vld=1 id=%h", k, ov[4+k], od[4+k], 8'(k + 1));
      end
    end
  endtask

  task automatic test_gap();
    int n;
    do_reset();
    cfg(8'd3, 64'h636261, 64'h0, 8'hFF);
    run("ab.c");
    n = count_pulses();
    checks++;
    if (n !== 1) begin failures++; $display("FAIL gap_count got=%0d exp=1", n); end
    checks++;
    if (ov[6] !== 1'b1 || od[6] !== 8'h02) begin
      failures++; $display("FAIL gap_hit got vld=%b id=%h exp vld=1 id=02", ov[6], od[6]);
    end
  endtask

  task automatic test_end_marker();
    int n;
    do_reset();
    cfg(8'd2, 64'h6261, 64'h0, 8'hFF);
    run("a|b");
    n = count_pulses();
    checks++;
    if (n !== 0) begin failures++; $display("FAIL end_split got=%0d pulses exp=0", n); end
    run("|ab");
    n = count_pulses();
    checks++;
    if (n !== 1) begin failures++; $display("FAIL end_restart_count got=%0d exp=1", n); end
    checks++;
    if (ov[5] !== 1'b1 || od[5] !== 8'h01) begin
      failures++; $display("FAIL end_restart got vld=%b id=%h exp vld=1 id=01", ov[5], od[5]);
    end
    // End beat right behind a matching beat must not drop that match.
    run("|ab|");
    n = count_pulses();
    checks++;
    if (n !== 1 || ov[5] !== 1'b1 || od[5] !== 8'h01) begin
      failures++; $display("FAIL end_inflight got pulses=%0d vld=%b id=%h exp pulses=1 vld=1 id=01", n, ov[5], od[5]);
    end
  endtask

  task automatic test_reset_inflight();
    int n;
    do_reset();
    cfg(8'd3, 64'h636261, 64'h0, 8'hFF);
    nsamp = 0;
    step(1'b1, "a", 1'b0);
    step(1'b1, "b", 1'b0);
    step(1'b1, "c", 1'b0);
    @(negedge aclk);
    areset        = 1'b1;
    s_axis.tvalid = 1'b0;
    #1;
    checks++;
    if (m_axis.tvalid !== 1'b0 || m_axis.tdata !== 8'h00) begin
      failures++; $display("FAIL inflight_reset got vld=%b id=%h exp vld=0 id=00", m_axis.tvalid, m_axis.tdata);
    end
    repeat (2) @(negedge aclk);
    checks++;
    if (m_axis.tvalid !== 1'b0 || m_axis.tdata !== 8'h00) begin
      failures++; $display("FAIL inflight_hold got vld=%b id=%h exp vld=0 id=00", m_axis.tvalid, m_axis.tdata);
    end
    areset = 1'b0;
    nsamp  = 0;
    for (int i = 0; i < 5; i++) step(1'b0, 8'h00, 1'b0);
    n = count_pulses();
    checks++;
    if (n !== 0) begin failures++; $display("FAIL inflight_after got=%0d pulses exp=0", n); end

    cfg(8'd0, 64'h636261, 64'h0, 8'hFF);
    run("abc");
    n = count_pulses();
    checks++;
    if (n !== 0) begin failures++; $display("FAIL ws_zero got=%0d pulses exp=0", n); end

    do_reset();
    cfg(8'd9, 64'h636261, 64'h0, 8'hFF);
    run("abcabcabc");
    n = count_pulses();
    checks++;
    if (n !== 0) begin failures++; $display("FAIL ws_nine got=%0d pulses exp=0", n); end
  endtask

  initial begin
    nsamp = 0;
    test_reset();
    test_basic();
    test_mask();
    test_back_to_back();
    test_gap();
    test_end_marker();
    test_reset_inflight();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
